alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised multi-cycle ALU. It is the successor to the 8-bit combinational ALU and sits in the execute stage of the CPU datapath. It keeps the FORWARD/ADD/AND/OR opcodes, adds SUB, MUL and two shifts, and registers RESULT and the flags behind a START/BUSY/DONE handshake. The control unit stalls the PC while BUSY is high.

## Interface
- WIDTH, 8: operand and result width, ≥ 4.
- CLK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  synchronous, active-low reset.
- START  input  1  request; sampled only while BUSY=0.
- SELECT  input  3  opcode, latched on accept.
- DATA1  input  WIDTH  operand A, latched on accept.
- DATA2  input  WIDTH  operand B / shift amount, latched on accept.
- RESULT  output  WIDTH  registered result; holds until the next completion.
- ZERO  output  1  registered; 1 iff RESULT == 0.
- CARRY  output  1  registered; meaning depends on the opcode (see Operation).
- BUSY  output  1  multi-cycle operation in progress.
- DONE  output  1  one-cycle pulse; RESULT and flags were updated on the previous edge.

## Operation
- Opcodes:
  - 000 FORWARD (B)
  - 001 ADD (A+B)
  - 010 AND
  - 011 OR
  - 100 SUB (A−B, two's complement)
  - 101 MUL (low WIDTH bits of A*B, unsigned)
  - 110 SLL (A << B)
  - 111 SRA (A >>> B, sign fill)
- Width rules: all arithmetic is modulo 2^WIDTH. The MUL accumulator is 2*WIDTH bits.
- Shift amount is B taken as unsigned and clamped to WIDTH. Shifting by WIDTH or more gives 0 for SLL and all copies of A's MSB for SRA.
- CARRY by opcode:
  - ADD: carry-out.
  - SUB: borrow (A < B unsigned).
  - MUL: 1 iff the upper WIDTH bits of the product are nonzero.
  - SLL/SRA: last bit shifted out, or 0 if the amount is 0.
  - FORWARD/AND/OR: 0.
- ZERO is taken from the actual RESULT for every opcode, not only ADD.
- State machine:
  - IDLE:
    - START=1 accepts the request and latches the operands.
    - Single-cycle ops (000–100, and shifts of amount 0) write RESULT/flags on the accepting edge and stay in IDLE.
    - MUL loads a counter with WIDTH; shifts load it with the clamped amount N. Both go to EXEC.
  - EXEC:
    - Each edge does one step: one shift-add iteration for MUL, or a one-bit shift, and decrements the counter.
    - On the edge where the counter reaches 0, RESULT/flags are written and the FSM returns to IDLE.
- Each shift step is one bit. No barrel shifter.
- BUSY = (state == EXEC).
- DONE is registered high for exactly one cycle after every edge that writes RESULT.

## Timing
- Reset (RESET=0 at an edge):
  - State goes to IDLE.
  - RESULT=0, ZERO=1, CARRY=0, BUSY=0, DONE=0.
  - The counter and operand registers are cleared.
- Reset mid-EXEC aborts the operation: no DONE, RESULT goes to 0.
- Latency for a request accepted at edge k: RESULT is written at edge k+M and DONE is high during the following cycle.
  - M=0 for single-cycle ops.
  - M=N for shifts.
  - M=WIDTH for MUL.
- BUSY is high from after edge k until after edge k+M, i.e. for M cycles.
- START while BUSY=1 is ignored. No queueing; the request is lost.
- START in the cycle where DONE=1 is accepted, so back-to-back issue is supported.
- Operand inputs may change freely after accept. Only the latched copies are used.
- RESULT, ZERO and CARRY change only on completion edges or on reset.

## Test plan (WIDTH=8)
- Reset: hold RESET=0 for 2 edges, then release -> RESULT=0x00, ZERO=1, CARRY=0, BUSY=0, DONE=0.
- ADD 0x7F+0x81 -> RESULT=0x00, ZERO=1, CARRY=1, DONE one cycle after accept, BUSY never high. SUB 0x05−0x07 -> 0xFE, CARRY=1, ZERO=0. Issue AND 0xF0&0x3C back-to-back in the DONE cycle -> 0x30.
- MUL 0x0D*0x0B -> RESULT=0x8F, CARRY=0, BUSY high for exactly 8 cycles, a single DONE pulse. MUL 0x10*0x10 -> 0x00, ZERO=1, CARRY=1.
- SRA 0x90 by 3 -> 0xF2, CARRY=0, BUSY 3 cycles. SLL 0x81 by 1 -> 0x02, CARRY=1. SLL 0x81 by 200 -> clamped to 8 cycles, 0x00, CARRY=1.
- Pulse START with ADD 1+1 while a MUL is BUSY -> ignored. The MUL result completes unchanged and only one DONE fires.
- Drive RESET=0 in cycle 4 of a MUL -> next cycle BUSY=0, RESULT=0x00, ZERO=1, and no DONE appears.

Source files
------------

// File: rtl/alu_seq_if.sv
// Request/response bundle between the execute-stage control and the multi-cycle ALU.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [2:0]       select;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             busy;
    logic             done;

    modport master (
        output start, select, data1, data2,
        input  result, zero, carry, busy, done
    );

    modport slave (
        input  start, select, data1, data2,
        output result, zero, carry, busy, done
    );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/add/sub, shift-add multiply, and bit-serial shifts
// behind a START/BUSY/DONE handshake with registered result and flags.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    alu_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, EXEC} state_e;
    typedef enum logic [2:0] {
        OP_FWD = 3'b000, OP_ADD = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
        OP_SUB = 3'b100, OP_MUL = 3'b101, OP_SLL = 3'b110, OP_SRA = 3'b111
    } op_e;

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic               done_q, done_d;

    logic               wr;
    logic [WIDTH-1:0]   wr_res;
    logic               wr_carry;
    logic [CW-1:0]      sh_amt;
    logic [WIDTH:0]     sum, diff, madd;
    logic [2*WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0]   sll_nx, sra_nx;
    logic               last;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            op_q    <= OP_FWD;
            cnt_q   <= '0;
            a_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b1;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        acc_d    = acc_q;
        res_d    = res_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        done_d   = 1'b0;
        wr       = 1'b0;
        wr_res   = '0;
        wr_carry = 1'b0;
        last     = (cnt_q == CW'(1));

        sh_amt = (bus.data2 >= WIDTH'(WIDTH)) ? CW'(WIDTH) : CW'(bus.data2);
        sum    = {1'b0, bus.data1} + {1'b0, bus.data2};
        diff   = {1'b0, bus.data1} - {1'b0, bus.data2};

        // Product register: high half accumulates, low half holds the multiplier
        // and is consumed LSB-first as the whole register shifts right.
        madd   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
        acc_nx = {madd, acc_q[WIDTH-1:1]};
        sll_nx = {a_q[WIDTH-2:0], 1'b0};
        sra_nx = {a_q[WIDTH-1], a_q[WIDTH-1:1]};

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d  = op_e'(bus.select);
                    a_d   = bus.data1;
                    acc_d = {{WIDTH{1'b0}}, bus.data2};
                    case (op_e'(bus.select))
                        OP_FWD: begin wr = 1'b1; wr_res = bus.data2; end
                        OP_ADD: begin wr = 1'b1; wr_res = sum[WIDTH-1:0]; wr_carry = sum[WIDTH]; end
                        OP_AND: begin wr = 1'b1; wr_res = bus.data1 & bus.data2; end
                        OP_OR:  begin wr = 1'b1; wr_res = bus.data1 | bus.data2; end
                        OP_SUB: begin wr = 1'b1; wr_res = diff[WIDTH-1:0]; wr_carry = diff[WIDTH]; end
                        OP_MUL: begin
                            cnt_d   = CW'(WIDTH);
                            state_d = EXEC;
                        end
                        default: begin
                            if (sh_amt == '0) begin
                                wr     = 1'b1;
                                wr_res = bus.data1;
                            end else begin
                                cnt_d   = sh_amt;
                                state_d = EXEC;
                            end
                        end
                    endcase
                end
            end
            default: begin
                cnt_d = cnt_q - CW'(1);
                case (op_q)
                    OP_MUL: begin
                        acc_d    = acc_nx;
                        wr       = last;
                        wr_res   = acc_nx[WIDTH-1:0];
                        wr_carry = |acc_nx[2*WIDTH-1:WIDTH];
                    end
                    OP_SLL: begin
                        a_d      = sll_nx;
                        wr       = last;
                        wr_res   = sll_nx;
                        wr_carry = a_q[WIDTH-1];
                    end
                    OP_SRA: begin
                        a_d      = sra_nx;
                        wr       = last;
                        wr_res   = sra_nx;
                        wr_carry = a_q[0];
                    end
                    default: ;
                endcase
                if (last || !(op_q inside {OP_MUL, OP_SLL, OP_SRA}))
                    state_d = IDLE;
            end
        endcase

        if (wr) begin
            res_d   = wr_res;
            zero_d  = (wr_res == '0);
            carry_d = wr_carry;
            done_d  = 1'b1;
        end
    end

    assign bus.result = res_q;
    assign bus.zero   = zero_q;
    assign bus.carry  = carry_q;
    assign bus.busy   = (state_q == EXEC);
    assign bus.done   = done_q;
endmodule

// File: tb/tb_alu_seq.sv
// Randomized + directed bench for alu_seq against an arithmetic reference model.
module tb_alu_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   errs = 0;
    int   nchk = 0;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(8)) bus ();
    alu_seq #(.WIDTH(8)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] r, output logic c, output int m);
        int                 n;
        logic [8:0]         s9;
        logic [15:0]        p;
        logic signed [15:0] ts;
        n = (b >= 8) ? 8 : int'(b);
        c = 1'b0;
        m = 0;
        case (op)
            3'd0: r = b;
            3'd1: begin s9 = {1'b0, a} + {1'b0, b}; r = s9[7:0]; c = s9[8]; end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: begin r = a - b; c = (a < b); end
            3'd5: begin p = 16'(a) * 16'(b); r = p[7:0]; c = (p[15:8] != 0); m = 8; end
            3'd6: begin p = 16'(a) << n; r = p[7:0]; c = p[8]; m = n; end
            default: begin ts = {a, 8'h00}; ts = ts >>> n; r = ts[15:8]; c = ts[7]; m = n; end
        endcase
    endfunction

    // Caller sits at a negedge; returns just after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.start  = 1'b1;
        bus.select = op;
        bus.data1  = a;
        bus.data2  = b;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.select = 3'($urandom);
        bus.data1  = 8'($urandom);
        bus.data2  = 8'($urandom);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input string tag);
        logic [7:0] er;
        logic       ec;
        int         em;
        int         busy_cnt;
        logic       seen;
        model(op, a, b, er, ec, em);
        issue(op, a, b);
        busy_cnt = 0;
        seen     = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) begin seen = 1'b1; break; end
            if (bus.busy) busy_cnt++;
        end
        chk({tag, "_done"}, 32'(seen), 32'd1);
        chk({tag, "_busy_cycles"}, busy_cnt, em);
        chk({tag, "_result"}, 32'(bus.result), 32'(er));
        chk({tag, "_zero"}, 32'(bus.zero), 32'(er == 8'h00));
        chk({tag, "_carry"}, 32'(bus.carry), 32'(ec));
    endtask

    initial begin
        int         dcnt;
        logic [7:0] rsav;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.select = '0;
        bus.data1  = '0;
        bus.data2  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_result", 32'(bus.result), 32'h00);
        chk("rst_zero", 32'(bus.zero), 32'd1);
        chk("rst_carry", 32'(bus.carry), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);

        run_op(3'd1, 8'h7F, 8'h81, "add");
        run_op(3'd4, 8'h05, 8'h07, "sub");
        run_op(3'd2, 8'hF0, 8'h3C, "and_b2b");
        run_op(3'd5, 8'h0D, 8'h0B, "mul");
        @(negedge clk);
        chk("mul_single_pulse", 32'(bus.done), 32'd0);
        run_op(3'd5, 8'h10, 8'h10, "mul_ovf");
        run_op(3'd7, 8'h90, 8'd3, "sra3");
        run_op(3'd6, 8'h81, 8'd1, "sll1");
        run_op(3'd6, 8'h81, 8'd200, "sll_clamp");
        run_op(3'd7, 8'h55, 8'd0, "sra0");

        // START while busy must be dropped
        @(negedge clk);
        issue(3'd5, 8'h0D, 8'h0B);
        repeat (2) @(negedge clk);
        bus.start = 1'b1; bus.select = 3'd1; bus.data1 = 8'h01; bus.data2 = 8'h01;
        @(posedge clk);
        #1 bus.start = 1'b0;
        dcnt = 0;
        rsav = 8'h00;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done) begin dcnt++; rsav = bus.result; end
        end
        chk("ign_done_count", dcnt, 1);
        chk("ign_result", 32'(rsav), 32'h8F);
        chk("ign_result_hold", 32'(bus.result), 32'h8F);

        // Reset mid-multiply aborts without DONE
        issue(3'd5, 8'hFF, 8'hFF);
        repeat (3) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_result", 32'(bus.result), 32'h00);
        chk("abort_zero", 32'(bus.zero), 32'd1);
        chk("abort_done", 32'(bus.done), 32'd0);
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) dcnt++;
        end
        chk("abort_no_done", dcnt, 0);

        for (int t = 0; t < 150; t++) begin
            logic [2:0] op;
            logic [7:0] a, b;
            op = 3'($urandom);
            a  = 8'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
            run_op(op, a, b, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end
endmodule
